// File: rtl/minimac3_sys_sync_if.sv
// Slot-synchroniser bus: software arm/ack plus the phy toggle/count crossing.
// master = software and phy-side partner, slave = the sys_clk synchroniser.
`timescale 1ns/1ps
interface minimac3_sys_sync_if #(
   parameter int NCHAN   = 2,
   parameter int COUNT_W = 11
);
   logic [NCHAN-1:0]         slot_arm;
   logic [NCHAN-1:0]         slot_ack;
   logic [NCHAN-1:0]         slot_ready;
   logic [NCHAN-1:0]         slot_done;
   logic [NCHAN-1:0]         slot_err;
   logic [NCHAN*COUNT_W-1:0] slot_count;
   logic                     irq;
   logic [NCHAN-1:0]         phy_arm_toggle;
   logic [NCHAN-1:0]         phy_done_toggle;
   logic [NCHAN*COUNT_W-1:0] phy_count;

   modport master (
      output slot_arm, slot_ack, phy_done_toggle, phy_count,
      input  slot_ready, slot_done, slot_err, slot_count, irq, phy_arm_toggle
   );

   modport slave (
      input  slot_arm, slot_ack, phy_done_toggle, phy_count,
      output slot_ready, slot_done, slot_err, slot_count, irq, phy_arm_toggle
   );
endinterface

// File: rtl/minimac3_sys_sync.sv
// sys_clk-side slot synchroniser: per-channel arm/done/ack state machine fed by
// toggle crossings from the phy domain, with completion count capture and irq.
`timescale 1ns/1ps
module minimac3_sys_sync #(
   parameter int NCHAN       = 2,
   parameter int COUNT_W     = 11,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   minimac3_sys_sync_if.slave   bus
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   logic [NCHAN-1:0] done_vec;

   genvar gi;
   generate
      for (gi = 0; gi < NCHAN; gi++) begin : g_ch
         state_t                 state_q;
         logic [SYNC_STAGES-1:0] sync_q;
         logic                   hist_q;
         logic [COUNT_W-1:0]     stage_q;
         logic [COUNT_W-1:0]     count_q;
         logic                   ready_q;
         logic                   done_q;
         logic                   err_q;
         logic                   arm_tog_q;
         logic                   done_evt;
         logic                   arm;
         logic                   ack;

         assign arm      = bus.slot_arm[gi];
         assign ack      = bus.slot_ack[gi];
         assign done_evt = sync_q[SYNC_STAGES-1] ^ hist_q;

         // The staging register needs no per-bit synchroniser: phy holds the
         // count stable from before its toggle flips, so it has settled long
         // before the toggle emerges from the synchroniser chain.
         always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
               state_q   <= ST_IDLE;
               sync_q    <= '0;
               hist_q    <= 1'b0;
               stage_q   <= '0;
               count_q   <= '0;
               ready_q   <= 1'b0;
               done_q    <= 1'b0;
               err_q     <= 1'b0;
               arm_tog_q <= 1'b0;
            end else begin
               sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.phy_done_toggle[gi]};
               hist_q  <= sync_q[SYNC_STAGES-1];
               stage_q <= bus.phy_count[gi*COUNT_W +: COUNT_W];

               // Ack clears the sticky error first so a same-cycle spurious
               // event below still leaves it set.
               if (ack) begin
                  err_q <= 1'b0;
               end

               case (state_q)
                  ST_IDLE: begin
                     if (done_evt) begin
                        err_q <= 1'b1;
                     end
                     if (arm) begin
                        state_q   <= ST_ARMED;
                        ready_q   <= 1'b1;
                        arm_tog_q <= ~arm_tog_q;
                     end
                  end
                  ST_ARMED: begin
                     if (done_evt) begin
                        state_q <= ST_DONE;
                        ready_q <= 1'b0;
                        done_q  <= 1'b1;
                        count_q <= stage_q;
                     end
                  end
                  ST_DONE: begin
                     if (done_evt) begin
                        err_q <= 1'b1;
                     end
                     if (ack) begin
                        done_q <= 1'b0;
                        if (arm) begin
                           state_q   <= ST_ARMED;
                           ready_q   <= 1'b1;
                           arm_tog_q <= ~arm_tog_q;
                        end else begin
                           state_q <= ST_IDLE;
                        end
                     end
                  end
                  default: begin
                     state_q <= ST_IDLE;
                     ready_q <= 1'b0;
                     done_q  <= 1'b0;
                  end
               endcase
            end
         end

         assign bus.slot_ready[gi]                      = ready_q;
         assign bus.slot_done[gi]                       = done_q;
         assign bus.slot_err[gi]                        = err_q;
         assign bus.phy_arm_toggle[gi]                  = arm_tog_q;
         assign bus.slot_count[gi*COUNT_W +: COUNT_W]   = count_q;
         assign done_vec[gi]                            = done_q;
      end
   endgenerate

   assign bus.irq = |done_vec;
endmodule

// File: tb/tb_minimac3_sys_sync.sv
// Bench for minimac3_sys_sync: directed vector table, SYNC_STAGES=3 latency
// sequence and randomized traffic against an event-schedule reference model.
`timescale 1ns/1ps
module tb_minimac3_sys_sync;
   localparam int NCH = 2;
   localparam int CW  = 11;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NCH-1:0]    arm = '0;
   logic [NCH-1:0]    ack = '0;
   logic [NCH-1:0]    tog = '0;
   logic [NCH*CW-1:0] pcount = '0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   minimac3_sys_sync_if #(.NCHAN(NCH), .COUNT_W(CW)) ifa ();
   minimac3_sys_sync_if #(.NCHAN(NCH), .COUNT_W(CW)) ifb ();

   assign ifa.slot_arm        = arm;
   assign ifa.slot_ack        = ack;
   assign ifa.phy_done_toggle = tog;
   assign ifa.phy_count       = pcount;
   assign ifb.slot_arm        = arm;
   assign ifb.slot_ack        = ack;
   assign ifb.phy_done_toggle = tog;
   assign ifb.phy_count       = pcount;

   minimac3_sys_sync #(.NCHAN(NCH), .COUNT_W(CW), .SYNC_STAGES(2)) dut_a (
      .sys_clk (clk),
      .sys_rst (rst),
      .bus     (ifa)
   );

   minimac3_sys_sync #(.NCHAN(NCH), .COUNT_W(CW), .SYNC_STAGES(3)) dut_b (
      .sys_clk (clk),
      .sys_rst (rst),
      .bus     (ifb)
   );

   // Reference model: a done event for a flip seen at edge n is due at edge
   // n+stages; slot state is tracked as ready/done flags per channel.
   int                cyc = 0;
   int                last_rst = 0;
   logic [NCH-1:0]    flip_at [0:8191];
   logic [NCH-1:0]    tog_prev = '0;
   logic [NCH*CW-1:0] stage_m = '0;
   logic [NCH-1:0]    m_ready [2];
   logic [NCH-1:0]    m_done  [2];
   logic [NCH-1:0]    m_err   [2];
   logic [NCH-1:0]    m_atog  [2];
   logic [NCH*CW-1:0] m_cnt   [2];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_update();
      cyc++;
      flip_at[cyc] = tog ^ tog_prev;
      tog_prev     = tog;
      for (int d = 0; d < 2; d++) begin
         int s;
         s = 2 + d;
         if (rst) begin
            m_ready[d] = '0;
            m_done[d]  = '0;
            m_err[d]   = '0;
            m_atog[d]  = '0;
            m_cnt[d]   = '0;
         end else begin
            for (int ch = 0; ch < NCH; ch++) begin
               bit evt;
               evt = 1'b0;
               if (cyc - s > last_rst) evt = flip_at[cyc - s][ch];
               if (ack[ch]) m_err[d][ch] = 1'b0;
               if (m_ready[d][ch]) begin
                  if (evt) begin
                     m_ready[d][ch]        = 1'b0;
                     m_done[d][ch]         = 1'b1;
                     m_cnt[d][ch*CW +: CW] = stage_m[ch*CW +: CW];
                  end
               end else begin
                  if (evt) m_err[d][ch] = 1'b1;
                  if (m_done[d][ch]) begin
                     if (ack[ch]) begin
                        m_done[d][ch] = 1'b0;
                        if (arm[ch]) begin
                           m_ready[d][ch] = 1'b1;
                           m_atog[d][ch]  = ~m_atog[d][ch];
                        end
                     end
                  end else if (arm[ch]) begin
                     m_ready[d][ch] = 1'b1;
                     m_atog[d][ch]  = ~m_atog[d][ch];
                  end
               end
            end
         end
      end
      if (rst) last_rst = cyc;
      stage_m = rst ? '0 : pcount;
   endtask

   task automatic model_check();
      chk("a_flags", {ifa.slot_ready, ifa.slot_done, ifa.slot_err, ifa.phy_arm_toggle},
          {m_ready[0], m_done[0], m_err[0], m_atog[0]});
      chk("a_count", ifa.slot_count, m_cnt[0]);
      chk("a_irq", ifa.irq, |m_done[0]);
      chk("b_flags", {ifb.slot_ready, ifb.slot_done, ifb.slot_err, ifb.phy_arm_toggle},
          {m_ready[1], m_done[1], m_err[1], m_atog[1]});
      chk("b_count", ifb.slot_count, m_cnt[1]);
      chk("b_irq", ifb.irq, |m_done[1]);
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      model_check();
   endtask

   typedef struct {
      logic           rst;
      logic [NCH-1:0] arm, ack, tog;
      logic [CW-1:0]  c0, c1;
      logic [NCH-1:0] e_ready, e_done, e_err, e_atog;
      logic [CW-1:0]  e_c0, e_c1;
      logic           e_irq;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic [1:0] a, input logic [1:0] k, input logic [1:0] t,
                      input logic [10:0] c0, input logic [10:0] c1,
                      input logic [1:0] er, input logic [1:0] ed, input logic [1:0] ee,
                      input logic [1:0] ea, input logic [10:0] ec0, input logic [10:0] ec1,
                      input logic ei);
      vec_t v;
      v.rst = r; v.arm = a; v.ack = k; v.tog = t; v.c0 = c0; v.c1 = c1;
      v.e_ready = er; v.e_done = ed; v.e_err = ee; v.e_atog = ea;
      v.e_c0 = ec0; v.e_c1 = ec1; v.e_irq = ei;
      vecs.push_back(v);
   endtask

   initial begin
      for (int i = 0; i < 8192; i++) flip_at[i] = '0;
      for (int d = 0; d < 2; d++) begin
         m_ready[d] = '0; m_done[d] = '0; m_err[d] = '0; m_atog[d] = '0; m_cnt[d] = '0;
      end

      //   rst arm   ack   tog   c0      c1      | ready done  err   atog  c0      c1      irq
      add(1, 2'b00, 2'b00, 2'b00, 11'h000, 11'h000, 2'b00, 2'b00, 2'b00, 2'b00, 11'h000, 11'h000, 0);
      add(1, 2'b00, 2'b00, 2'b00, 11'h000, 11'h000, 2'b00, 2'b00, 2'b00, 2'b00, 11'h000, 11'h000, 0);
      add(0, 2'b00, 2'b00, 2'b00, 11'h000, 11'h000, 2'b00, 2'b00, 2'b00, 2'b00, 11'h000, 11'h000, 0);
      add(0, 2'b01, 2'b00, 2'b00, 11'h000, 11'h000, 2'b01, 2'b00, 2'b00, 2'b01, 11'h000, 11'h000, 0);
      add(0, 2'b00, 2'b00, 2'b00, 11'h5EA, 11'h000, 2'b01, 2'b00, 2'b00, 2'b01, 11'h000, 11'h000, 0);
      add(0, 2'b00, 2'b00, 2'b01, 11'h5EA, 11'h000, 2'b01, 2'b00, 2'b00, 2'b01, 11'h000, 11'h000, 0);
      add(0, 2'b00, 2'b00, 2'b01, 11'h5EA, 11'h000, 2'b01, 2'b00, 2'b00, 2'b01, 11'h000, 11'h000, 0);
      add(0, 2'b00, 2'b00, 2'b01, 11'h5EA, 11'h000, 2'b00, 2'b01, 2'b00, 2'b01, 11'h5EA, 11'h000, 1);
      add(0, 2'b00, 2'b01, 2'b01, 11'h5EA, 11'h000, 2'b00, 2'b00, 2'b00, 2'b01, 11'h5EA, 11'h000, 0);
      add(0, 2'b11, 2'b00, 2'b01, 11'h5EA, 11'h000, 2'b11, 2'b00, 2'b00, 2'b10, 11'h5EA, 11'h000, 0);
      add(0, 2'b00, 2'b00, 2'b01, 11'h040, 11'h7FF, 2'b11, 2'b00, 2'b00, 2'b10, 11'h5EA, 11'h000, 0);
      add(0, 2'b00, 2'b00, 2'b10, 11'h040, 11'h7FF, 2'b11, 2'b00, 2'b00, 2'b10, 11'h5EA, 11'h000, 0);
      add(0, 2'b00, 2'b00, 2'b10, 11'h040, 11'h7FF, 2'b11, 2'b00, 2'b00, 2'b10, 11'h5EA, 11'h000, 0);
      add(0, 2'b00, 2'b00, 2'b10, 11'h040, 11'h7FF, 2'b00, 2'b11, 2'b00, 2'b10, 11'h040, 11'h7FF, 1);
      add(0, 2'b00, 2'b10, 2'b10, 11'h040, 11'h7FF, 2'b00, 2'b01, 2'b00, 2'b10, 11'h040, 11'h7FF, 1);
      add(0, 2'b00, 2'b00, 2'b00, 11'h040, 11'h7FF, 2'b00, 2'b01, 2'b00, 2'b10, 11'h040, 11'h7FF, 1);
      add(0, 2'b00, 2'b00, 2'b00, 11'h040, 11'h7FF, 2'b00, 2'b01, 2'b00, 2'b10, 11'h040, 11'h7FF, 1);
      add(0, 2'b00, 2'b00, 2'b00, 11'h040, 11'h7FF, 2'b00, 2'b01, 2'b10, 2'b10, 11'h040, 11'h7FF, 1);
      add(0, 2'b00, 2'b10, 2'b00, 11'h040, 11'h7FF, 2'b00, 2'b01, 2'b00, 2'b10, 11'h040, 11'h7FF, 1);
      add(0, 2'b01, 2'b01, 2'b00, 11'h040, 11'h7FF, 2'b01, 2'b00, 2'b00, 2'b11, 11'h040, 11'h7FF, 0);
      add(0, 2'b01, 2'b00, 2'b00, 11'h040, 11'h7FF, 2'b01, 2'b00, 2'b00, 2'b11, 11'h040, 11'h7FF, 0);
      add(0, 2'b00, 2'b00, 2'b01, 11'h123, 11'h7FF, 2'b01, 2'b00, 2'b00, 2'b11, 11'h040, 11'h7FF, 0);
      add(1, 2'b00, 2'b00, 2'b00, 11'h123, 11'h7FF, 2'b00, 2'b00, 2'b00, 2'b00, 11'h000, 11'h000, 0);
      add(0, 2'b00, 2'b00, 2'b00, 11'h123, 11'h7FF, 2'b00, 2'b00, 2'b00, 2'b00, 11'h000, 11'h000, 0);
      add(0, 2'b00, 2'b00, 2'b00, 11'h123, 11'h7FF, 2'b00, 2'b00, 2'b00, 2'b00, 11'h000, 11'h000, 0);
      add(0, 2'b00, 2'b00, 2'b00, 11'h123, 11'h7FF, 2'b00, 2'b00, 2'b00, 2'b00, 11'h000, 11'h000, 0);
      add(0, 2'b01, 2'b00, 2'b00, 11'h123, 11'h7FF, 2'b01, 2'b00, 2'b00, 2'b01, 11'h000, 11'h000, 0);
      add(0, 2'b00, 2'b00, 2'b00, 11'h3C3, 11'h7FF, 2'b01, 2'b00, 2'b00, 2'b01, 11'h000, 11'h000, 0);
      add(0, 2'b00, 2'b00, 2'b01, 11'h3C3, 11'h7FF, 2'b01, 2'b00, 2'b00, 2'b01, 11'h000, 11'h000, 0);
      add(0, 2'b00, 2'b00, 2'b01, 11'h3C3, 11'h7FF, 2'b01, 2'b00, 2'b00, 2'b01, 11'h000, 11'h000, 0);
      add(0, 2'b00, 2'b00, 2'b01, 11'h3C3, 11'h7FF, 2'b00, 2'b01, 2'b00, 2'b01, 11'h3C3, 11'h000, 1);
      add(0, 2'b01, 2'b00, 2'b01, 11'h3C3, 11'h7FF, 2'b00, 2'b01, 2'b00, 2'b01, 11'h3C3, 11'h000, 1);
      add(0, 2'b00, 2'b10, 2'b01, 11'h3C3, 11'h7FF, 2'b00, 2'b01, 2'b00, 2'b01, 11'h3C3, 11'h000, 1);
      add(0, 2'b00, 2'b00, 2'b00, 11'h3C3, 11'h7FF, 2'b00, 2'b01, 2'b00, 2'b01, 11'h3C3, 11'h000, 1);
      add(0, 2'b00, 2'b00, 2'b00, 11'h3C3, 11'h7FF, 2'b00, 2'b01, 2'b00, 2'b01, 11'h3C3, 11'h000, 1);
      add(0, 2'b00, 2'b01, 2'b00, 11'h3C3, 11'h7FF, 2'b00, 2'b00, 2'b01, 2'b01, 11'h3C3, 11'h000, 0);
      add(0, 2'b00, 2'b01, 2'b00, 11'h3C3, 11'h7FF, 2'b00, 2'b00, 2'b00, 2'b01, 11'h3C3, 11'h000, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst; arm = vecs[i].arm; ack = vecs[i].ack; tog = vecs[i].tog;
         pcount = {vecs[i].c1, vecs[i].c0};
         step();
         $display("vec %0d: rst=%b arm=%b ack=%b tog=%b -> ready=%b done=%b err=%b atog=%b cnt=%h irq=%b",
                  i, rst, arm, ack, tog, ifa.slot_ready, ifa.slot_done, ifa.slot_err,
                  ifa.phy_arm_toggle, ifa.slot_count, ifa.irq);
         chk($sformatf("vec%0d_flags", i),
             {ifa.slot_ready, ifa.slot_done, ifa.slot_err, ifa.phy_arm_toggle},
             {vecs[i].e_ready, vecs[i].e_done, vecs[i].e_err, vecs[i].e_atog});
         chk($sformatf("vec%0d_count", i), ifa.slot_count, {vecs[i].e_c1, vecs[i].e_c0});
         chk($sformatf("vec%0d_irq", i), ifa.irq, vecs[i].e_irq);
      end
      rst = 1'b0; arm = '0; ack = '0;

      // Done latency with two versus three synchroniser stages on ch1.
      arm = 2'b10; step(); arm = '0;
      pcount[CW +: CW] = 11'h2AA; step();
      tog[1] = 1'b1; step();
      $display("ss: flip edge a_done=%b b_done=%b", ifa.slot_done, ifb.slot_done);
      step();
      chk("ss_k1_a", ifa.slot_done[1], 1'b0);
      chk("ss_k1_b", ifb.slot_done[1], 1'b0);
      step();
      $display("ss: k+2 a_done=%b b_done=%b", ifa.slot_done, ifb.slot_done);
      chk("ss_k2_a", ifa.slot_done[1], 1'b1);
      chk("ss_k2_b", ifb.slot_done[1], 1'b0);
      step();
      $display("ss: k+3 a_done=%b b_done=%b", ifa.slot_done, ifb.slot_done);
      chk("ss_k3_b", ifb.slot_done[1], 1'b1);
      chk("ss_k3_b_cnt", ifb.slot_count[CW +: CW], 11'h2AA);
      ack = 2'b10; step(); ack = '0;
      chk("ss_ack_irq", {ifa.irq, ifb.irq}, 2'b00);

      // Randomized traffic, including occasional resets with the phy toggles restarting.
      for (int n = 0; n < 1200; n++) begin
         rst = ($urandom_range(0, 299) == 0);
         for (int ch = 0; ch < NCH; ch++) begin
            arm[ch] = ($urandom_range(0, 5) == 0);
            ack[ch] = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) == 0) tog[ch] = ~tog[ch];
            if ($urandom_range(0, 7) == 0) pcount[ch*CW +: CW] = CW'($urandom);
         end
         if (rst) tog = '0;
         step();
         if (rst || (arm != 0) || (ack != 0) || (flip_at[cyc] != 0))
            $display("rnd %0d: rst=%b arm=%b ack=%b flip=%b -> a_done=%b b_done=%b a_err=%b",
                     n, rst, arm, ack, flip_at[cyc], ifa.slot_done, ifb.slot_done, ifa.slot_err);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
